// File: rtl/pkt_arbiter_pkg.sv
// Shared constants and types for the two-source SpiNNaker packet arbiter.
// Sets the default packet width and names the source indices.
package pkt_arbiter_pkg;

  localparam int PACKET_BITS_DEF = 72;

  localparam int SRC0 = 0;
  localparam int SRC1 = 1;

  // Encodes which source won the most recent grant.
  typedef enum logic {
    SRC_0 = 1'b0,
    SRC_1 = 1'b1
  } src_e;

endpackage

// File: rtl/pkt_arbiter_rr_arb2.sv
// Two-request round-robin arbiter that produces a one-hot grant.
// When both sources request, the one that did not win last time is granted.
module rr_arb2
  import pkt_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_en,
  input  src_e       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    // NOTE: give o_gnt a default first, so that no path through the block leaves it unassigned and no latch is inferred.
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = (i_last_grant == SRC_1) ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/pkt_arbiter.sv
// Merges two valid/ready packet streams into one through a one-entry output register.
// Round-robin arbitration happens in rr_arb2; the register and the last_grant state live here.
module pkt_arbiter
  import pkt_arbiter_pkg::*;
#(
  parameter int PACKET_BITS = PACKET_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arb_en_in,
  input  logic [PACKET_BITS-1:0] pkt0_data_in,
  input  logic                   pkt0_vld_in,
  output logic                   pkt0_rdy_out,
  input  logic [PACKET_BITS-1:0] pkt1_data_in,
  input  logic                   pkt1_vld_in,
  output logic                   pkt1_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in,
  output logic [1:0]             arb_cnt_out
);

  logic                   r_vld;
  logic [PACKET_BITS-1:0] r_data;
  src_e                   r_last_grant;

  logic       w_free;
  logic       w_arb_en;
  logic [1:0] w_gnt;

  // The register is free when it is empty or is emptying this cycle, so it can refill on every edge.
  assign w_free   = !r_vld || pkt_rdy_in;
  assign w_arb_en = reset && arb_en_in && w_free;

  rr_arb2 u_rr_arb2 (
    .i_req        ({pkt1_vld_in, pkt0_vld_in}),
    .i_en         (w_arb_en),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  assign pkt0_rdy_out = w_gnt[SRC0];
  assign pkt1_rdy_out = w_gnt[SRC1];
  assign arb_cnt_out  = {pkt1_vld_in & w_gnt[SRC1], pkt0_vld_in & w_gnt[SRC0]};

  assign pkt_data_out = r_data;
  assign pkt_vld_out  = r_vld;

  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments for all sequential state, so that every register samples the values from before the edge.
    if (!reset) begin
      r_vld        <= 1'b0;
      r_data       <= '0;
      r_last_grant <= SRC_1;
    end else if (|w_gnt) begin
      r_vld        <= 1'b1;
      r_data       <= w_gnt[SRC1] ? pkt1_data_in : pkt0_data_in;
      r_last_grant <= w_gnt[SRC1] ? SRC_1 : SRC_0;
    end else if (pkt_rdy_in) begin
      r_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed and randomised self-checking bench for pkt_arbiter.
// Inputs change 1 time unit after each rising edge; outputs are sampled before the next edge.
module tb_pkt_arbiter;

  localparam int PB = 72;

  logic          clk = 1'b0;
  logic          reset;
  logic          arb_en_in;
  logic [PB-1:0] pkt0_data_in, pkt1_data_in;
  logic          pkt0_vld_in, pkt1_vld_in;
  logic          pkt0_rdy_out, pkt1_rdy_out;
  logic [PB-1:0] pkt_data_out;
  logic          pkt_vld_out;
  logic          pkt_rdy_in;
  logic [1:0]    arb_cnt_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_arbiter #(.PACKET_BITS(PB)) dut (
    .clk          (clk),
    .reset        (reset),
    .arb_en_in    (arb_en_in),
    .pkt0_data_in (pkt0_data_in),
    .pkt0_vld_in  (pkt0_vld_in),
    .pkt0_rdy_out (pkt0_rdy_out),
    .pkt1_data_in (pkt1_data_in),
    .pkt1_vld_in  (pkt1_vld_in),
    .pkt1_rdy_out (pkt1_rdy_out),
    .pkt_data_out (pkt_data_out),
    .pkt_vld_out  (pkt_vld_out),
    .pkt_rdy_in   (pkt_rdy_in),
    .arb_cnt_out  (arb_cnt_out)
  );

  task automatic check(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PB-1:0] p0(input int n);
    return {8'hA0, 32'h0000_0000, 32'(n)};
  endfunction

  function automatic logic [PB-1:0] p1(input int n);
    return {8'hB1, 32'h0000_0000, 32'(n)};
  endfunction

  initial begin
    logic          m_vld, m_last, m_free;
    logic [PB-1:0] m_data;
    logic [1:0]    exp_g;
    logic [31:0]   seq0, seq1;
    int            pulses0, pulses1, deliv0, deliv1, pend0, pend1;

    // Hold reset with both sources valid: nothing may be granted.
    reset = 1'b0; arb_en_in = 1'b1; pkt_rdy_in = 1'b1;
    pkt0_vld_in = 1'b1; pkt1_vld_in = 1'b1;
    pkt0_data_in = p0(99); pkt1_data_in = p1(99);
    tick();
    tick();
    check("rst_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b00);
    check("rst_cnt", arb_cnt_out, 2'b00);
    check("rst_vld", pkt_vld_out, 1'b0);
    check("rst_data", pkt_data_out, '0);

    // Both sources valid continuously: alternate 0,1,0,1 at one packet per cycle.
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pkt0_data_in = p0(i); pkt1_data_in = p1(i);
      #1;
      check("rr_rdy", {pkt1_rdy_out, pkt0_rdy_out}, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_cnt", arb_cnt_out, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("rr_vld", pkt_vld_out, 1'b1);
      check("rr_data", pkt_data_out, (i % 2 == 0) ? p0(i) : p1(i));
    end

    // Output backpressure on a single source-0 packet.
    pkt1_vld_in = 1'b0;
    pkt0_data_in = 72'h0000_0000_AB00_0001;
    #1;
    check("bp_load_rdy", pkt0_rdy_out, 1'b1);
    tick();
    check("bp_load_data", pkt_data_out, 72'h0000_0000_AB00_0001);
    pkt_rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_rdy", pkt0_rdy_out, 1'b0);
      tick();
      check("bp_hold_vld", pkt_vld_out, 1'b1);
      check("bp_hold_data", pkt_data_out, 72'h0000_0000_AB00_0001);
    end
    pkt0_data_in = 72'h0000_0000_AB00_0002;
    pkt_rdy_in = 1'b1;
    #1;
    check("bp_release_rdy", pkt0_rdy_out, 1'b1);
    check("bp_release_cnt", arb_cnt_out, 2'b01);
    tick();
    check("bp_next_data", pkt_data_out, 72'h0000_0000_AB00_0002);
    pkt0_vld_in = 1'b0;
    #1;
    check("bp_idle_rdy", pkt0_rdy_out, 1'b0);
    tick();
    check("bp_drain_vld", pkt_vld_out, 1'b0);

    // Source 1 alone for four cycles, then a tie goes to source 0.
    pkt1_vld_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pkt1_data_in = p1(10 + k);
      #1;
      check("s1_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b10);
      tick();
      check("s1_data", pkt_data_out, p1(10 + k));
    end
    pkt0_vld_in = 1'b1; pkt0_data_in = p0(20);
    #1;
    check("s1_tie_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b01);
    tick();
    check("s1_tie_data", pkt_data_out, p0(20));
    pkt0_vld_in = 1'b0; pkt1_vld_in = 1'b0;
    tick();

    // Enable drops while a packet is held: deliver it, then grant nothing until re-enabled.
    pkt0_vld_in = 1'b1; pkt0_data_in = p0(30); pkt_rdy_in = 1'b0;
    #1;
    check("en_load_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b01);
    tick();
    check("en_load_data", pkt_data_out, p0(30));
    arb_en_in = 1'b0; pkt1_vld_in = 1'b1; pkt1_data_in = p1(31);
    #1;
    check("en_off_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b00);
    tick();
    check("en_off_hold", pkt_data_out, p0(30));
    pkt_rdy_in = 1'b1;
    #1;
    check("en_off_deliver_vld", pkt_vld_out, 1'b1);
    check("en_off_deliver_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b00);
    check("en_off_deliver_cnt", arb_cnt_out, 2'b00);
    tick();
    check("en_off_empty", pkt_vld_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("en_off_idle_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b00);
      tick();
      check("en_off_idle_vld", pkt_vld_out, 1'b0);
    end
    arb_en_in = 1'b1;
    #1;
    check("en_on_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b10);
    tick();
    check("en_on_data", pkt_data_out, p1(31));

    // Reset while holding a source-0 packet: discard it, and the first tie afterwards goes to source 0.
    pkt1_vld_in = 1'b0; pkt0_data_in = p0(40);
    #1;
    check("mr_load_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b01);
    tick();
    check("mr_load_data", pkt_data_out, p0(40));
    pkt_rdy_in = 1'b0; reset = 1'b0; pkt1_vld_in = 1'b1;
    #1;
    check("mr_rdy", {pkt1_rdy_out, pkt0_rdy_out}, 2'b00);
    check("mr_cnt", arb_cnt_out, 2'b00);
    tick();
    check("mr_vld", pkt_vld_out, 1'b0);
    check("mr_data", pkt_data_out, '0);
    reset = 1'b1; pkt_rdy_in = 1'b1;
    pkt0_data_in = p0(41); pkt1_data_in = p1(41);
    #1;
    check("mr_first_tie", {pkt1_rdy_out, pkt0_rdy_out}, 2'b01);
    tick();
    check("mr_first_data", pkt_data_out, p0(41));
    pkt0_vld_in = 1'b0; pkt1_vld_in = 1'b0;
    tick();

    // Random valid/ready/enable traffic checked against a reference model of the merge.
    m_vld = 1'b0; m_last = 1'b0; m_data = '0;
    seq0 = 32'd0; seq1 = 32'd0;
    pulses0 = 0; pulses1 = 0; deliv0 = 0; deliv1 = 0;
    for (int c = 0; c < 10000; c++) begin
      pkt0_vld_in  = ($urandom_range(0, 3) != 0);
      pkt1_vld_in  = ($urandom_range(0, 3) != 0);
      pkt_rdy_in   = ($urandom_range(0, 2) != 0);
      arb_en_in    = ($urandom_range(0, 7) != 0);
      pkt0_data_in = {8'hA0, 32'($urandom), seq0};
      pkt1_data_in = {8'hB1, 32'($urandom), seq1};
      #1;
      m_free = !m_vld || pkt_rdy_in;
      exp_g  = 2'b00;
      if (arb_en_in && m_free) begin
        if (pkt0_vld_in && pkt1_vld_in) exp_g = m_last ? 2'b01 : 2'b10;
        else                            exp_g = {pkt1_vld_in, pkt0_vld_in};
      end
      check("rand_rdy", {pkt1_rdy_out, pkt0_rdy_out}, exp_g);
      check("rand_vld", pkt_vld_out, m_vld);
      pulses0 += int'(arb_cnt_out[0]);
      pulses1 += int'(arb_cnt_out[1]);
      if (pkt_vld_out && pkt_rdy_in) begin
        check("rand_data", pkt_data_out, m_data);
        if (pkt_data_out[71:64] == 8'hA0) deliv0++;
        else if (pkt_data_out[71:64] == 8'hB1) deliv1++;
      end
      if (exp_g != 2'b00) begin
        m_vld  = 1'b1;
        m_data = exp_g[1] ? pkt1_data_in : pkt0_data_in;
        m_last = exp_g[1];
        if (exp_g[1]) seq1++;
        else          seq0++;
      end else if (pkt_rdy_in) begin
        m_vld = 1'b0;
      end
      tick();
    end
    pend0 = (m_vld && m_data[71:64] == 8'hA0) ? 1 : 0;
    pend1 = (m_vld && m_data[71:64] == 8'hB1) ? 1 : 0;
    check("sb_pulses0", 72'(pulses0), 72'(deliv0 + pend0));
    check("sb_pulses1", 72'(pulses1), 72'(deliv1 + pend1));
    check("sb_accepted0", 72'(pulses0), 72'(seq0));
    check("sb_accepted1", 72'(pulses1), 72'(seq1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_arbiter.md
PKT_ARBITER -- requirements
Module: pkt_arbiter

Interface
REQ-001 Parameter: PACKET_BITS, default 72, width of one SpiNNaker packet word.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 arb_en_in  input  1  1 = new grants allowed; 0 = no new grants, output register still drains.
REQ-005 pkt0_data_in  input  PACKET_BITS  packet from source 0.
REQ-006 pkt0_vld_in  input  1  source 0 packet valid.
REQ-007 pkt0_rdy_out  output  1  source 0 packet accepted this cycle.
REQ-008 pkt1_data_in  input  PACKET_BITS  packet from source 1.
REQ-009 pkt1_vld_in  input  1  source 1 packet valid.
REQ-010 pkt1_rdy_out  output  1  source 1 packet accepted this cycle.
REQ-011 pkt_data_out  output  PACKET_BITS  merged packet stream to the receiver.
REQ-012 pkt_vld_out  output  1  merged packet valid.
REQ-013 pkt_rdy_in  input  1  receiver ready.
REQ-014 arb_cnt_out  output  2  one-cycle pulse per packet accepted; bit N = source N.

Function
REQ-015 A transfer on any port SHALL occur only in a cycle where vld and rdy are both 1.
REQ-016 Output stage: one-entry register holding data and pkt_vld_out.
- Free when pkt_vld_out=0, or when pkt_vld_out=1 and pkt_rdy_in=1 in the same cycle.
REQ-017 Grant: a source is granted only when all of the following hold:
- arb_en_in=1;
- output stage free;
- that source's vld=1.
REQ-018 Tie-break: exactly one source is granted per cycle.
- Only one source valid: grant it.
- Both valid: grant the source not recorded in last_grant (round-robin).
REQ-019 pktN_rdy_out SHALL equal the grant for source N, combinationally.
- It may depend on pktN_vld_in; upstream vld must not depend on rdy.
REQ-020 On grant to N:
- the output register loads pktN_data_in and pkt_vld_out=1 on the next edge (latency 1 cycle);
- last_grant <= N.
REQ-021 Output hold: if pkt_vld_out=1 and pkt_rdy_in=0, pkt_data_out and pkt_vld_out SHALL hold unchanged.
REQ-022 Drain without grant: if pkt_vld_out=1, pkt_rdy_in=1 and no grant, pkt_vld_out <= 0.
REQ-023 Throughput: SHALL sustain one packet per cycle when pkt_rdy_in is held at 1.
REQ-024 arb_cnt_out[N] SHALL equal pktN_vld_in AND pktN_rdy_out (combinational).
REQ-025 last_grant SHALL change only on a grant.
REQ-026 arb_en_in falling while pkt_vld_out=1: the held packet is still delivered, and no packet is lost or duplicated.
REQ-027 Data SHALL pass through bit-exact; no packet inspection or modification.

Reset
REQ-028 While reset=0 at a clock edge, on that edge:
- pkt_vld_out <= 0;
- pkt_data_out <= 0;
- last_grant <= 1, so source 0 wins the first tie.
REQ-029 While reset=0, pkt0_rdy_out, pkt1_rdy_out and arb_cnt_out SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held packet; the first grant after release follows REQ-017/018.

Structure
REQ-031 Shared package holds:
- PACKET_BITS default;
- source-index constants (SRC0=0, SRC1=1).
REQ-032 Arbitration is the single natural sub-module, rr_arb2:
- inputs: two requests, enable, last_grant;
- outputs: one-hot grant.
REQ-033 Output register and last_grant remain in pkt_arbiter.

Verification
REQ-034 Scenario: both sources valid continuously, pkt_rdy_in=1, after reset.
- Required response: accepted order 0,1,0,1,...; one packet per cycle; first output one cycle after first grant.
REQ-035 Scenario: output backpressure.
- Stimulus: pkt0 data=72'h0000_0000_AB00_0001 valid; pkt_rdy_in=0 for 5 cycles.
- Required response: output holds that value for 5 cycles; pkt0_rdy_out=0 while the register is full; transfers on the first cycle pkt_rdy_in=1.
REQ-036 Scenario: only source 1 valid for 4 cycles, then both valid.
- Required response: four source-1 grants, then source 0 granted first.
REQ-037 Scenario: arb_en_in=0 with a packet held, then pkt_rdy_in=1.
- Required response: held packet delivered; pkt_vld_out then 0; no further rdy until arb_en_in=1.
REQ-038 Scenario: reset=0 asserted while pkt_vld_out=1.
- Required response: next cycle pkt_vld_out=0 and pkt_data_out=0; after release, a tie grants source 0.
REQ-039 Scenario: scoreboard check over 10,000 random vld/rdy cycles.
- Required response: arb_cnt_out pulse totals equal delivered-packet totals per source; no loss; no duplication.
